// File: rtl/cipher_pkg.sv
// Shared constants, FSM state type and start-parameter check for the XOR cipher sequencer.
package cipher_pkg;

    localparam int DATA_W   = 8;
    localparam int MAX_KEYS = 16;
    localparam int LEN_W    = 8;
    localparam int KIDX_W   = $clog2(MAX_KEYS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // A job needs at least one byte and a key count in 1..MAX_KEYS.
    function automatic logic start_legal(input logic [LEN_W-1:0]  len,
                                         input logic [KIDX_W:0]   nk);
        return (len != '0) && (nk != '0) && (nk <= (KIDX_W+1)'(MAX_KEYS));
    endfunction

endpackage

// File: rtl/xor_key_table.sv
// Key register file: synchronous write, combinational read by key index, cleared on Reset.
module xor_key_table
    import cipher_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [KIDX_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [KIDX_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [MAX_KEYS-1:0][DATA_W-1:0] mem;

    // Clear all keys on reset, otherwise write one entry per strobe.
    always_ff @(posedge Clk) begin
        if (Reset)
            mem <= '0;
        else if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xor_cipher_sequencer.sv
// Walks a message through a byte-wide XOR with a rotating key schedule.
// One-deep output register with valid/ready; full throughput when the sink is ready.
module xor_cipher_sequencer
    import cipher_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              key_wr_en,
    input  logic [KIDX_W-1:0] key_wr_addr,
    input  logic [DATA_W-1:0] key_wr_data,
    input  logic              start,
    input  logic [LEN_W-1:0]  msg_len,
    input  logic [KIDX_W:0]   num_keys,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state;
    logic [KIDX_W-1:0] kidx;
    logic [LEN_W-1:0]  bytes_left;
    logic [KIDX_W:0]   nkeys_q;
    logic [DATA_W-1:0] key_rd;
    logic              xfer;
    logic              key_we;
    logic              last_key;

    // Output slot is free when empty or being drained this cycle.
    assign in_ready = (state == RUN) && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state != IDLE);
    // Key writes are only honoured between jobs so a running schedule never changes.
    assign key_we   = key_wr_en && (state == IDLE);
    assign last_key = ({1'b0, kidx} == (nkeys_q - 1'b1));

    xor_key_table u_key_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (key_we),
        .wr_addr (key_wr_addr),
        .wr_data (key_wr_data),
        .rd_addr (kidx),
        .rd_data (key_rd)
    );

    // Job FSM, key/length counters, output register and status pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            kidx       <= '0;
            bytes_left <= '0;
            nkeys_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_legal(msg_len, num_keys)) begin
                            state      <= RUN;
                            kidx       <= '0;
                            bytes_left <= msg_len;
                            nkeys_q    <= num_keys;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (xfer) begin
                        out_data   <= in_data ^ key_rd;
                        out_valid  <= 1'b1;
                        kidx       <= last_key ? '0 : kidx + 1'b1;
                        bytes_left <= bytes_left - 1'b1;
                        if (bytes_left == LEN_W'(1))
                            state <= DRAIN;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_cipher_sequencer.sv
// Scoreboard bench: driver pushes expected ciphertext on each accepted byte,
// monitor pops and compares on each output handshake.
module tb_xor_cipher_sequencer;
    import cipher_pkg::*;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              key_wr_en;
    logic [KIDX_W-1:0] key_wr_addr;
    logic [DATA_W-1:0] key_wr_data;
    logic              start;
    logic [LEN_W-1:0]  msg_len;
    logic [KIDX_W:0]   num_keys;
    logic              abort;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_key [MAX_KEYS];
    logic              stall_pending = 1'b0;
    logic [DATA_W-1:0] stall_data;

    xor_cipher_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .key_wr_en   (key_wr_en),
        .key_wr_addr (key_wr_addr),
        .key_wr_data (key_wr_data),
        .start       (start),
        .msg_len     (msg_len),
        .num_keys    (num_keys),
        .abort       (abort),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: sample just after the falling edge, when inputs for the next rising edge are settled.
    always @(negedge Clk) begin
        #1;
        if (Reset) begin
            stall_pending = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (err)  err_cnt++;
            if (out_valid) begin
                if (stall_pending) check("stall_stable", out_data, stall_data);
                if (out_ready) begin
                    if (exp_q.size() == 0) check("spurious_out", 1, 0);
                    else                   check("out_data", out_data, exp_q.pop_front());
                    stall_pending = 1'b0;
                end else begin
                    stall_pending = 1'b1;
                    stall_data    = out_data;
                end
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    task automatic write_key(input int addr, input logic [DATA_W-1:0] data);
        @(negedge Clk);
        key_wr_en   = 1'b1;
        key_wr_addr = KIDX_W'(addr);
        key_wr_data = data;
        model_key[addr] = data;
        @(negedge Clk);
        key_wr_en = 1'b0;
    endtask

    task automatic bad_start(input int len, input int nk);
        @(negedge Clk);
        start = 1'b1; msg_len = LEN_W'(len); num_keys = (KIDX_W+1)'(nk);
        @(negedge Clk);
        start = 1'b0;
        #1;
        check("err_pulse", err, 1);
        check("err_busy", busy, 0);
        @(negedge Clk);
        #1;
        check("err_clear", err, 0);
        check("err_no_out", out_valid, 0);
        check("err_still_idle", busy, 0);
    endtask

    // One job. abort_at>0 aborts after that many bytes; drain_reset resets while in DRAIN;
    // sw_en writes a key in the same cycle as start; poke tries key writes and stray starts while busy.
    task automatic run_job(input int nk, input int len, input int rdy_pct, input bit seq_data,
                           input int abort_at, input bit poke, input bit drain_reset,
                           input bit sw_en, input int sw_addr, input logic [DATA_W-1:0] sw_data);
        int i;
        int cyc;
        int base_done;
        int base_err;
        logic [DATA_W-1:0] d;
        base_done = done_cnt;
        base_err  = err_cnt;
        @(negedge Clk);
        start = 1'b1; msg_len = LEN_W'(len); num_keys = (KIDX_W+1)'(nk);
        if (sw_en) begin
            key_wr_en = 1'b1; key_wr_addr = KIDX_W'(sw_addr); key_wr_data = sw_data;
            model_key[sw_addr] = sw_data;
        end
        @(negedge Clk);
        start = 1'b0; key_wr_en = 1'b0;
        i = 0; cyc = 0;
        while (1) begin
            in_valid = seq_data ? 1'b1 : ($urandom_range(0, 3) != 0);
            d = seq_data ? i[7:0] : 8'($urandom);
            in_data   = d;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            key_wr_en = poke; key_wr_addr = '0; key_wr_data = 8'hFF;
            start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
            msg_len   = '0; num_keys = '0;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(d ^ model_key[i % nk]);
                i++;
            end
            cyc++;
            if (i == len || (abort_at > 0 && i == abort_at) || cyc >= 2000) break;
            @(negedge Clk);
        end
        check("accept_count", i, (abort_at > 0) ? abort_at : len);

        if (abort_at > 0) begin
            @(negedge Clk);
            in_valid = 1'b1; in_data = 8'($urandom); out_ready = 1'b0;
            abort = 1'b1; key_wr_en = 1'b0; start = 1'b0;
            @(negedge Clk);
            abort = 1'b0; in_valid = 1'b0;
            #1;
            check("abort_out_valid", out_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_in_ready", in_ready, 0);
            exp_q.delete();
            @(negedge Clk);
            #2;
            check("abort_no_done", done_cnt - base_done, 0);
            check("abort_no_err", err_cnt - base_err, 0);
            check("abort_stays_idle", out_valid, 0);
        end else if (drain_reset) begin
            @(negedge Clk);
            in_valid = 1'b0; out_ready = 1'b0; key_wr_en = 1'b0; start = 1'b0;
            #1;
            check("drain_busy", busy, 1);
            check("drain_out_valid", out_valid, 1);
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            exp_q.delete();
            for (int k = 0; k < MAX_KEYS; k++) model_key[k] = '0;
            @(negedge Clk);
            #2;
            check("rst_no_done", done_cnt - base_done, 0);
        end else begin
            cyc = 0;
            do begin
                @(negedge Clk);
                in_valid = 1'b0; key_wr_en = 1'b0; start = 1'b0;
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                #1;
                cyc++;
            end while (!done && cyc < 300);
            check("done_seen", done, 1);
            if (rdy_pct >= 100) check("done_latency", cyc, 2);
            check("busy_at_done", busy, 0);
            check("queue_empty", exp_q.size(), 0);
            @(negedge Clk);
            #2;
            check("done_pulse", done, 0);
            check("done_count", done_cnt - base_done, 1);
            check("no_err_in_job", err_cnt - base_err, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; key_wr_en = 1'b0; key_wr_addr = '0; key_wr_data = '0;
        start = 1'b0; msg_len = '0; num_keys = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < MAX_KEYS; k++) model_key[k] = '0;
        repeat (2) @(negedge Clk);
        #1;
        check("rst_out_valid0", out_valid, 0);
        check("rst_out_data0", out_data, 0);
        check("rst_busy0", busy, 0);
        check("rst_done0", done, 0);
        check("rst_err0", err, 0);
        check("rst_in_ready0", in_ready, 0);
        Reset = 1'b0;

        write_key(0, 8'hAA);
        write_key(1, 8'h55);
        write_key(2, 8'h0F);
        run_job(3, 5, 100, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        run_job(3, 5, 50,  1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        bad_start(0, 3);
        bad_start(5, 0);
        bad_start(5, 17);

        run_job(3, 5, 100, 1'b1, 0, 1'b1, 1'b0, 1'b0, 0, 8'h00);
        run_job(3, 5, 100, 1'b1, 2, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        run_job(3, 5, 100, 1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        for (int k = 0; k < MAX_KEYS; k++) write_key(k, 8'($urandom));
        run_job(16, 255, 80, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);
        run_job(1, 7, 100, 1'b0, 0, 1'b0, 1'b0, 1'b1, 0, 8'($urandom));
        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(1, 16)), int'($urandom_range(1, 40)),
                    int'($urandom_range(30, 100)), 1'b0, 0, 1'($urandom_range(0, 1)),
                    1'b0, 1'b1, int'($urandom_range(0, 15)), 8'($urandom));

        run_job(3, 4, 100, 1'b1, 0, 1'b0, 1'b1, 1'b0, 0, 8'h00);
        run_job(3, 5, 100, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
